// File: rtl/buyruk_kuyrugu_pkg.sv
// Shared definitions for the instruction decoupling queue: packed entry layout
// {compressed, ps, buy} and its field offsets.
package buyruk_kuyrugu_pkg;

    localparam int DERINLIK_VARSAYILAN = 4;
    localparam int PS_BIT_VARSAYILAN   = 32;
    localparam int BUY_BIT_VARSAYILAN  = 32;

    // Entry width: PC + instruction + compressed flag.
    function automatic int bk_girdi_bit(input int ps_bit, input int buy_bit);
        return ps_bit + buy_bit + 1;
    endfunction

    function automatic int bk_buy_ofs();
        return 0;
    endfunction

    function automatic int bk_ps_ofs(input int buy_bit);
        return buy_bit;
    endfunction

    function automatic int bk_comp_ofs(input int ps_bit, input int buy_bit);
        return ps_bit + buy_bit;
    endfunction

endpackage

// File: rtl/buyruk_kuyrugu_kuyruk_bellek.sv
// Entry storage for the queue: register array with synchronous write and
// asynchronous (show-ahead) read; data is never reset.
module kuyruk_bellek #(
    parameter int DERINLIK = 4,
    parameter int GENISLIK = 65
) (
    input  logic                        clk_i,
    input  logic                        yaz_en,
    input  logic [$clog2(DERINLIK)-1:0] yaz_adr,
    input  logic [GENISLIK-1:0]         yaz_veri,
    input  logic [$clog2(DERINLIK)-1:0] oku_adr,
    output logic [GENISLIK-1:0]         oku_veri
);
    localparam int PTR_BIT = $clog2(DERINLIK);

    logic [GENISLIK-1:0] mem [DERINLIK];

    generate
        for (genvar gi = 0; gi < DERINLIK; gi++) begin : g_girdi
            always_ff @(posedge clk_i) begin
                if (yaz_en && (yaz_adr == PTR_BIT'(gi))) begin
                    mem[gi] <= yaz_veri;
                end
            end
        end
    endgenerate

    assign oku_veri = mem[oku_adr];

endmodule

// File: rtl/buyruk_kuyrugu.sv
// Decoupling queue between getir and coz_yazmacoku. Optional zero-latency
// bypass when empty is enabled by defining BUYRUK_KUYRUGU_BAYPAS_EN.
module buyruk_kuyrugu
    import buyruk_kuyrugu_pkg::*;
#(
    parameter int DERINLIK = 4,
    parameter int PS_BIT   = 32,
    parameter int BUY_BIT  = 32
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        gtr_gecerli_i,
    input  logic [PS_BIT-1:0]           gtr_ps_i,
    input  logic [BUY_BIT-1:0]          gtr_buy_i,
    input  logic                        gtr_compressed_i,
    output logic                        gtr_hazir_o,
    output logic                        coz_gecerli_o,
    output logic [PS_BIT-1:0]           coz_ps_o,
    output logic [BUY_BIT-1:0]          coz_buy_o,
    output logic                        coz_compressed_o,
    input  logic                        coz_hazir_i,
    input  logic                        ddb_temizle_i,
    output logic [$clog2(DERINLIK):0]   doluluk_o
);
    localparam int PTR_BIT   = $clog2(DERINLIK);
    localparam int CNT_BIT   = PTR_BIT + 1;
    localparam int GIRDI_BIT = bk_girdi_bit(PS_BIT, BUY_BIT);
    localparam int PS_OFS    = bk_ps_ofs(BUY_BIT);
    localparam int COMP_OFS  = bk_comp_ofs(PS_BIT, BUY_BIT);
    localparam logic [CNT_BIT-1:0] DOLU = CNT_BIT'(DERINLIK);

    logic [PTR_BIT-1:0]   yaz_ptr_reg, yaz_ptr_next;
    logic [PTR_BIT-1:0]   oku_ptr_reg, oku_ptr_next;
    logic [CNT_BIT-1:0]   sayac_reg, sayac_next;
    logic [GIRDI_BIT-1:0] yaz_veri, oku_veri;
    logic                 bos, yaz_en, bellek_oku, dogrudan;

    assign bos         = (sayac_reg == '0);
    assign gtr_hazir_o = (sayac_reg != DOLU);
    assign yaz_veri    = {gtr_compressed_i, gtr_ps_i, gtr_buy_i};

    always_comb begin
        coz_gecerli_o    = !bos;
        coz_buy_o        = oku_veri[BUY_BIT-1:0];
        coz_ps_o         = oku_veri[PS_OFS +: PS_BIT];
        coz_compressed_o = oku_veri[COMP_OFS];
        dogrudan         = 1'b0;
`ifdef BUYRUK_KUYRUGU_BAYPAS_EN
        // Empty queue: present the producer's entry directly; a same-cycle
        // consume never touches storage.
        if (bos && !ddb_temizle_i) begin
            coz_gecerli_o    = gtr_gecerli_i;
            coz_buy_o        = gtr_buy_i;
            coz_ps_o         = gtr_ps_i;
            coz_compressed_o = gtr_compressed_i;
            dogrudan         = gtr_gecerli_i && coz_hazir_i;
        end
`endif
    end

    assign yaz_en     = gtr_gecerli_i && gtr_hazir_o && !ddb_temizle_i && !dogrudan;
    assign bellek_oku = !bos && coz_hazir_i && !ddb_temizle_i;

    always_comb begin
        yaz_ptr_next = yaz_ptr_reg;
        oku_ptr_next = oku_ptr_reg;
        sayac_next   = sayac_reg;
        if (ddb_temizle_i) begin
            yaz_ptr_next = '0;
            oku_ptr_next = '0;
            sayac_next   = '0;
        end else begin
            if (yaz_en)     yaz_ptr_next = yaz_ptr_reg + 1'b1;
            if (bellek_oku) oku_ptr_next = oku_ptr_reg + 1'b1;
            case ({yaz_en, bellek_oku})
                2'b10:   sayac_next = sayac_reg + 1'b1;
                2'b01:   sayac_next = sayac_reg - 1'b1;
                default: sayac_next = sayac_reg;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            yaz_ptr_reg <= '0;
            oku_ptr_reg <= '0;
            sayac_reg   <= '0;
        end else begin
            yaz_ptr_reg <= yaz_ptr_next;
            oku_ptr_reg <= oku_ptr_next;
            sayac_reg   <= sayac_next;
        end
    end

    assign doluluk_o = sayac_reg;

    kuyruk_bellek #(
        .DERINLIK (DERINLIK),
        .GENISLIK (GIRDI_BIT)
    ) u_bellek (
        .clk_i    (clk_i),
        .yaz_en   (yaz_en),
        .yaz_adr  (yaz_ptr_reg),
        .yaz_veri (yaz_veri),
        .oku_adr  (oku_ptr_reg),
        .oku_veri (oku_veri)
    );

endmodule
